multi_cycle_adder: RTL

//  - Parametrised, sequential successor to the 4-bit ripple full adder.
//  - Adds two WIDTH-bit operands plus carry-in, one SLICE-bit chunk per clock, LSB chunk first.
//  - Completes in WIDTH/SLICE cycles, using one SLICE-bit combinational adder slice.
//  - start/busy/done handshake; registered sum, carry-out and signed-overflow flag.
//  - Used wherever a wide add can trade latency for area.

---
 rtl/multi_cycle_adder_pkg.sv | 11 +
 rtl/multi_cycle_adder_slice.sv | 28 ++
 rtl/multi_cycle_adder.sv | 109 ++++++++++
 3 files changed

// File: rtl/multi_cycle_adder_pkg.sv
// Shared constants for the multi-cycle adder: FSM state encodings and default sizing.
package multi_cycle_adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SLICE = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/multi_cycle_adder_slice.sv
// Combinational N-bit ripple adder slice; c_msb is the carry into the top bit,
// which the parent uses for signed-overflow detection.
module adder_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         co,
  output logic         c_msb
);

  logic [N:0] c;

  // NOTE: every bit of c and sum is written on every pass, so no latch is inferred.
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co    = c[N];
  assign c_msb = c[N-1];

endmodule

// File: rtl/multi_cycle_adder.sv
// Sequential WIDTH-bit adder: one SLICE-bit chunk per clock, LSB chunk first,
// with a start/busy/done handshake and registered sum, carry-out and overflow.
module multi_cycle_adder
  import multi_cycle_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int SLICE = DEFAULT_SLICE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             overflow
);

  localparam int N  = WIDTH / SLICE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH % SLICE) != 0 || SLICE < 1 || SLICE > WIDTH) begin : g_bad_params
    $error("multi_cycle_adder: WIDTH must be a positive multiple of SLICE");
  end

  logic [1:0]       state_q;
  logic [IW-1:0]    idx_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] psum_q;
  logic [WIDTH-1:0] psum_next;
  logic             carry_q;
  logic [SLICE-1:0] slice_a;
  logic [SLICE-1:0] slice_b;
  logic [SLICE-1:0] slice_sum;
  logic             slice_co;
  logic             slice_cmsb;
  logic             last_chunk;

  assign slice_a    = a_q[int'(idx_q)*SLICE +: SLICE];
  assign slice_b    = b_q[int'(idx_q)*SLICE +: SLICE];
  assign last_chunk = (int'(idx_q) == N - 1);

  adder_slice #(.N(SLICE)) u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .cin   (carry_q),
    .sum   (slice_sum),
    .co    (slice_co),
    .c_msb (slice_cmsb)
  );

  // Partial sum with the current chunk merged in; on the last chunk this is the result.
  always_comb begin
    psum_next = psum_q;
    psum_next[int'(idx_q)*SLICE +: SLICE] = slice_sum;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      psum_q   <= '0;
      carry_q  <= 1'b0;
      sum      <= '0;
      co       <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            psum_q  <= '0;
            idx_q   <= '0;
            state_q <= ST_ADD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_ADD: begin
          psum_q  <= psum_next;
          carry_q <= slice_co;
          if (last_chunk) begin
            idx_q    <= '0;
            sum      <= psum_next;
            co       <= slice_co;
            overflow <= slice_co ^ slice_cmsb;
            state_q  <= ST_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q == ST_ADD);
  assign done = (state_q == ST_DONE);

endmodule
